// File: rtl/grant_requester.sv
// grant_requester: requester-side agent for the tree priority selector.
// Queues jobs per channel, requests the selector, then runs a fixed-length burst
// for the granted channel and pulses done on the last beat.
// Optional macro GRANT_CHECK_EN adds a sticky grant_err output that flags
// multi-hot grants and grants to channels that were not requesting.
module grant_requester #(
    parameter int NUM_CH    = 8,
    parameter int CNT_W     = 3,
    parameter int BURST_LEN = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] job_valid,
    output logic [NUM_CH-1:0] job_ready,
    output logic [NUM_CH-1:0] req,
    output logic              en,
    input  logic [NUM_CH-1:0] gnt,
    output logic              busy,
    output logic [NUM_CH-1:0] owner,
    output logic              done,
    output logic [NUM_CH-1:0] done_ch
`ifdef GRANT_CHECK_EN
    ,
    output logic              grant_err
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        BUSY
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic [BEAT_W-1:0] beat;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] enq;
    logic [NUM_CH-1:0] deq;
    logic              any_pending;
    logic              grant_take;
    logic              last_beat;

    // Per-channel queue status: non-empty, not-full, accepted enqueue, grant decrement.
    always_comb begin
        pending    = '0;
        job_ready  = '0;
        enq        = '0;
        deq        = '0;
        grant_take = (state == REQ) && (gnt != '0);
        for (int i = 0; i < NUM_CH; i++) begin
            pending[i]   = (cnt[i] != '0);
            job_ready[i] = (cnt[i] != CNT_MAX);
            enq[i]       = job_valid[i] && job_ready[i];
            deq[i]       = grant_take && gnt[i] && pending[i];
        end
        any_pending = |pending;
        last_beat   = (beat == LAST_BEAT);
    end

    // Pending-job counters; an enqueue and a grant on the same channel cancel out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (enq[i] && !deq[i]) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end else if (deq[i] && !enq[i]) begin
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and selector-facing outputs; the selector answers in the same cycle.
    always_comb begin
        state_next = state;
        req        = '0;
        en         = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        done_ch    = '0;
        case (state)
            IDLE: begin
                if (any_pending) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                en  = 1'b1;
                req = pending;
                if (grant_take) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (last_beat) begin
                    done       = 1'b1;
                    done_ch    = owner;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Burst owner and beat counter; the grant is latched as given, even if illegal.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner <= '0;
            beat  <= '0;
        end else if (grant_take) begin
            owner <= gnt;
            beat  <= '0;
        end else if (state == BUSY) begin
            if (last_beat) begin
                owner <= '0;
                beat  <= '0;
            end else begin
                beat <= beat + BEAT_W'(1);
            end
        end
    end

`ifdef GRANT_CHECK_EN
    // Sticky flag for grants that are multi-hot or hit a non-requesting channel.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_err <= 1'b0;
        end else if (state == REQ && gnt != '0) begin
            if (((gnt & (gnt - NUM_CH'(1))) != '0) || ((gnt & ~pending) != '0)) begin
                grant_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_grant_requester.sv
// Testbench for grant_requester. Plays the priority selector (highest index wins),
// keeps a scoreboard of expected done_ch values and checks burst timing.
// Build with GRANT_CHECK_EN defined to also check the grant_err output.
module tb_grant_requester;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] job_valid;
    logic [7:0] job_ready;
    logic [7:0] req;
    logic       en;
    logic [7:0] gnt;
    logic       busy;
    logic [7:0] owner;
    logic       done;
    logic [7:0] done_ch;
`ifdef GRANT_CHECK_EN
    logic       grant_err;
`endif

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    logic [7:0] sb[$];
    int         grant_cyc[$];
    logic [7:0] grant_req[$];

    logic       force_on;
    logic [7:0] force_val;
    logic       hold;

    grant_requester #(
        .NUM_CH   (8),
        .CNT_W    (3),
        .BURST_LEN(4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .job_valid(job_valid),
        .job_ready(job_ready),
        .req      (req),
        .en       (en),
        .gnt      (gnt),
        .busy     (busy),
        .owner    (owner),
        .done     (done),
        .done_ch  (done_ch)
`ifdef GRANT_CHECK_EN
        ,
        .grant_err(grant_err)
`endif
    );

    // Free-running clock, 10 ns period.
    always #5 clock = ~clock;

    // Cycle counter used for grant spacing.
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [7:0] pick_msb(input logic [7:0] r);
        logic [7:0] g;
        g = '0;
        for (int i = 0; i < 8; i++) begin
            if (r[i]) begin
                g    = '0;
                g[i] = 1'b1;
            end
        end
        return g;
    endfunction

    // Selector model: combinational highest-index priority, or a forced grant.
    always_comb begin
        if (force_on) begin
            gnt = force_val;
        end else if (en && !hold) begin
            gnt = pick_msb(req);
        end else begin
            gnt = '0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] jv);
        step();
        job_valid = jv;
        step();
        job_valid = '0;
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        checkOutput("drain_timeout", sb.size(), 0);
    endtask

    // Scoreboard: every done pulse pops one expected done_ch; grants are logged.
    always @(negedge clock) begin
        if (!reset) begin
            if (done) begin
                logic [7:0] exp;
                logic       have;
                have = (sb.size() != 0);
                exp  = have ? sb.pop_front() : 8'h00;
                checkOutput("done_ch", {1'b1, done_ch}, {have, exp});
            end
            if (en && gnt != '0) begin
                grant_cyc.push_back(cyc);
                grant_req.push_back(req);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        reset     = 1'b1;
        job_valid = '0;
        force_on  = 1'b0;
        force_val = '0;
        hold      = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_req", req, 8'h00);
        checkOutput("reset_en_busy_done", {en, busy, done}, 3'b000);
        checkOutput("reset_owner", owner, 8'h00);
        checkOutput("reset_done_ch", done_ch, 8'h00);
        checkOutput("reset_ready", job_ready, 8'hFF);
`ifdef GRANT_CHECK_EN
        checkOutput("reset_grant_err", grant_err, 1'b0);
`endif
        step();
        reset = 1'b0;

        // Idle with no jobs.
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            checkOutput("idle", {req, en, busy, job_ready}, {8'h00, 2'b00, 8'hFF});
        end

        // Single job on channel 2.
        step();
        job_valid = 8'h04;
        sb.push_back(8'h04);
        step();
        job_valid = '0;
        @(negedge clock);
        checkOutput("t1_no_req", {req, en}, 9'h000);
        step();
        @(negedge clock);
        checkOutput("t2_req", {req, en}, {8'h04, 1'b1});
        for (int k = 3; k <= 6; k++) begin
            step();
            @(negedge clock);
            checkOutput("burst_busy", busy, 1'b1);
            checkOutput("burst_owner", owner, 8'h04);
            checkOutput("burst_done", done, (k == 6));
        end
        step();
        @(negedge clock);
        checkOutput("t7_idle", {busy, en, req, owner}, 0);
        step();
        @(negedge clock);
        checkOutput("t8_no_rerequest", en, 1'b0);

        // Two channels at once: highest index first, then the other.
        grant_cyc.delete();
        grant_req.delete();
        sb.push_back(8'h40);
        sb.push_back(8'h02);
        applyStimulus(8'h42);
        waitDrain(40);
        repeat (3) @(negedge clock);
        checkOutput("grant_count", grant_cyc.size(), 2);
        if (grant_cyc.size() == 2) begin
            checkOutput("grant_spacing", grant_cyc[1] - grant_cyc[0], 6);
            checkOutput("first_req", grant_req[0], 8'h42);
            checkOutput("second_req", grant_req[1], 8'h02);
        end

        // Fill channel 0 while the selector withholds the grant.
        hold = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            job_valid = 8'h01;
            @(negedge clock);
            if (k == 7) checkOutput("ready_after6", job_ready, 8'hFF);
            if (k == 8) checkOutput("ready_after7", job_ready, 8'hFE);
        end
        step();
        job_valid = '0;
        @(negedge clock);
        checkOutput("full_ready", job_ready, 8'hFE);
        checkOutput("full_req", {req, en}, {8'h01, 1'b1});
        for (int k = 0; k < 7; k++) sb.push_back(8'h01);
        hold = 1'b0;
        waitDrain(80);
        repeat (15) @(negedge clock);
        checkOutput("full_drained", {busy, en, job_ready}, {2'b00, 8'hFF});

        // Enqueue on channel 3 in the same cycle as its grant.
        sb.push_back(8'h08);
        sb.push_back(8'h08);
        step();
        job_valid = 8'h08;
        step();
        job_valid = '0;
        step();
        job_valid = 8'h08;
        @(negedge clock);
        checkOutput("coincident_req", {req, en}, {8'h08, 1'b1});
        step();
        job_valid = '0;
        waitDrain(40);
        repeat (12) @(negedge clock);
        checkOutput("coincident_idle", {busy, en}, 2'b00);
`ifdef GRANT_CHECK_EN
        checkOutput("legal_no_err", grant_err, 1'b0);
`endif

        // Reset during beat 2 of a burst: nothing completes, queue is lost.
        step();
        job_valid = 8'h21;
        step();
        job_valid = '0;
        step();
        step();
        step();
        step();
        checkOutput("pre_reset_busy", {busy, owner}, {1'b1, 8'h20});
        reset = 1'b1;
        #1;
        checkOutput("mid_reset_outputs", {req, en, busy, done, owner, done_ch}, 0);
        checkOutput("mid_reset_ready", job_ready, 8'hFF);
        step();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            checkOutput("post_reset_idle", {req, en, busy, done}, 0);
        end

        // Multi-hot grant is latched as given and drains both channels.
        force_val = 8'h03;
        force_on  = 1'b1;
        step();
        job_valid = 8'h03;
        step();
        job_valid = '0;
        step();
        sb.push_back(8'h03);
        @(negedge clock);
        checkOutput("multi_req", {req, en}, {8'h03, 1'b1});
`ifdef GRANT_CHECK_EN
        checkOutput("err_before", grant_err, 1'b0);
`endif
        step();
        @(negedge clock);
        checkOutput("multi_owner", {busy, owner}, {1'b1, 8'h03});
`ifdef GRANT_CHECK_EN
        checkOutput("err_set", grant_err, 1'b1);
`endif
        waitDrain(30);
        repeat (4) @(negedge clock);
        checkOutput("multi_cleared", {busy, en}, 2'b00);
`ifdef GRANT_CHECK_EN
        checkOutput("err_sticky", grant_err, 1'b1);
`endif
        force_on = 1'b0;
        step();
        reset = 1'b1;
        #1;
`ifdef GRANT_CHECK_EN
        checkOutput("err_cleared", grant_err, 1'b0);
`endif
        checkOutput("final_reset", {busy, en, owner}, 0);
        step();
        reset = 1'b0;
        repeat (2) @(negedge clock);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
